skew_fifo_bank: RTL and testbench

- Parametrised successor to the B-operand memory for the DIM x DIM systolic array.
- Holds one shift-register FIFO per lane (DEPTH deep) and staggers each lane's enable by SKEW cycles per lane index, producing the diagonal wavefront the array consumes.
- Adds beyond the previous block:
  - configurable depth and skew;
  - per-lane occupancy tracking with a primed/valid indication;
  - a synchronous clear;
  - a bank-level busy flag.

---
 rtl/skew_fifo_pkg.sv | 17 +
 rtl/skew_fifo_bank_if.sv | 17 +
 rtl/lane_fifo.sv | 41 ++++
 rtl/skew_fifo_bank.sv | 59 +++++
 tb/tb_skew_fifo_bank.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/skew_fifo_pkg.sv
// Shared types and sizing helpers for the skewed B-operand FIFO bank.
package skew_fifo_pkg;

  localparam int DEFAULT_BITS_AB = 8;

  typedef logic signed [DEFAULT_BITS_AB-1:0] elem_t;

  // Lane r taps the stagger pipe at r*SKEW, so the last lane needs (DIM-1)*SKEW+1 stages.
  function automatic int pipe_len(input int dim, input int skew);
    return (dim - 1) * skew + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skew_fifo_bank_if.sv
// Streaming bus of the FIFO bank: request/flush in, staggered per-lane elements out.
interface skew_fifo_bank_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);

  logic                      en;
  logic                      clr;
  logic signed [BITS_AB-1:0] Bin  [DIM];
  logic signed [BITS_AB-1:0] Bout [DIM];
  logic [DIM-1:0]            vld_out;
  logic                      busy;

  modport master (output en, clr, Bin, input Bout, vld_out, busy);
  modport slave  (input en, clr, Bin, output Bout, vld_out, busy);

endinterface

// File: rtl/lane_fifo.sv
// One lane of the bank: a DEPTH-stage shift FIFO with saturating occupancy count.
module lane_fifo
  import skew_fifo_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = cnt_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [BITS_AB-1:0] d,
  output logic signed [BITS_AB-1:0] q,
  output logic [CNT_W-1:0]          cnt,
  output logic                      primed
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic signed [BITS_AB-1:0] stage [DEPTH];

  // A full lane keeps shifting; the oldest element simply falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      cnt <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (cnt != FULL) cnt <= cnt + 1'b1;
    end
  end

  assign q      = stage[DEPTH-1];
  assign primed = (cnt == FULL);

endmodule

// File: rtl/skew_fifo_bank.sv
// DIM lane FIFOs whose enables are staggered by SKEW cycles per lane, forming
// the diagonal wavefront consumed by the systolic array.
module skew_fifo_bank
  import skew_fifo_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int DEPTH   = 8,
  parameter int SKEW    = 1
) (
  input logic              clk,
  input logic              rst_n,
  skew_fifo_bank_if.slave  bus
);

  localparam int PIPE_LEN = pipe_len(DIM, SKEW);
  localparam int CNT_W    = cnt_w(DEPTH);

  logic [PIPE_LEN-1:0]       pipe;
  logic [DIM-1:0]            lane_en;
  logic [DIM-1:0]            primed;
  logic signed [BITS_AB-1:0] q [DIM];
  logic [CNT_W-1:0]          occupancy_unused [DIM];

  // The pipe shifts every cycle; bit 0 holds the request sampled at the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (bus.clr) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | PIPE_LEN'(bus.en);
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    assign lane_en[r] = pipe[r*SKEW];

    lane_fifo #(
      .BITS_AB (BITS_AB),
      .DEPTH   (DEPTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (bus.clr),
      .en     (lane_en[r]),
      .d      (bus.Bin[r]),
      .q      (q[r]),
      .cnt    (occupancy_unused[r]),
      .primed (primed[r])
    );

    assign bus.Bout[r]    = lane_en[r] ? q[r] : '0;
    assign bus.vld_out[r] = lane_en[r] & primed[r];
  end

  assign bus.busy = |pipe;

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Randomised scoreboard bench for skew_fifo_bank against a queue-based lane model.
module tb_skew_fifo_bank;
  import skew_fifo_pkg::*;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int DEPTH   = 8;
  localparam int SKEW    = 2;
  localparam int PLEN    = (DIM - 1) * SKEW + 1;

  typedef struct packed {
    logic [DIM-1:0][BITS_AB-1:0] bout;
    logic [DIM-1:0]              vld;
    logic                        busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  elem_t lane_q [DIM][$];
  bit    en_hist [$];
  exp_t  exp_q [$];

  skew_fifo_bank_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  skew_fifo_bank #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .DEPTH   (DEPTH),
    .SKEW    (SKEW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Lane r is enabled in the cycle after the edge that sampled en r*SKEW edges ago.
  function automatic bit lane_on(input int r);
    if (en_hist.size() > r * SKEW) return en_hist[r*SKEW];
    return 1'b0;
  endfunction

  // Reference model: each lane holds the last DEPTH elements it accepted, oldest first.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      en_hist.delete();
      exp_q.delete();
      for (int r = 0; r < DIM; r++) lane_q[r].delete();
    end else begin
      if (bus.clr) begin
        en_hist.delete();
        for (int r = 0; r < DIM; r++) lane_q[r].delete();
      end else begin
        for (int r = 0; r < DIM; r++) begin
          if (lane_on(r)) begin
            lane_q[r].push_back(bus.Bin[r]);
            if (lane_q[r].size() > DEPTH) void'(lane_q[r].pop_front());
          end
        end
        en_hist.push_front(bus.en);
        if (en_hist.size() > PLEN) void'(en_hist.pop_back());
      end
      e = '0;
      for (int r = 0; r < DIM; r++) begin
        if (lane_on(r) && lane_q[r].size() == DEPTH) begin
          e.vld[r]  = 1'b1;
          e.bout[r] = lane_q[r][0];
        end
      end
      foreach (en_hist[i]) e.busy |= en_hist[i];
      exp_q.push_back(e);
    end
  end

  task automatic checkOutput(input exp_t e, input string tag);
    int bad_lane;
    checks++;
    if (bus.busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s busy got %0b want %0b at %0t", tag, bus.busy, e.busy, $time);
    end
    checks++;
    if (bus.vld_out !== e.vld) begin
      errors++;
      $display("[TB] FAIL %s vld_out got %b want %b at %0t", tag, bus.vld_out, e.vld, $time);
    end
    checks++;
    bad_lane = -1;
    for (int r = DIM - 1; r >= 0; r--) if (bus.Bout[r] !== e.bout[r]) bad_lane = r;
    if (bad_lane >= 0) begin
      errors++;
      $display("[TB] FAIL %s Bout[%0d] got %h want %h at %0t", tag, bad_lane,
               bus.Bout[bad_lane], e.bout[bad_lane], $time);
    end
  endtask

  // Monitor: one expected record per clocked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) checkOutput(exp_q.pop_front(), "stream");
  end

  // mode 0: 10*r+t ramp, 1: random, 2: negative extremes
  task automatic applyStimulus(input bit en, input bit clr, input int mode, input int t);
    @(negedge clk);
    bus.en  = en;
    bus.clr = clr;
    for (int r = 0; r < DIM; r++) begin
      case (mode)
        0:       bus.Bin[r] = elem_t'(10 * r + t);
        1:       bus.Bin[r] = elem_t'($urandom);
        default: bus.Bin[r] = ((t + r) % 2 == 0) ? elem_t'(8'h80) : elem_t'(8'hFF);
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    for (int r = 0; r < DIM; r++) bus.Bin[r] = '0;
    repeat (3) @(posedge clk);
    #2 checkOutput('0, "in_reset");
    @(negedge clk) rst_n = 1'b1;

    idle(20);

    for (int t = 0; t < 16; t++) applyStimulus(1'b1, 1'b0, 0, t);
    idle(PLEN + 4);

    applyStimulus(1'b1, 1'b0, 1, 0);
    idle(PLEN + 3);

    for (int t = 0; t < 12; t++) applyStimulus(1'b1, 1'b0, 1, t);
    idle(5);
    for (int t = 0; t < 20; t++) applyStimulus(1'b1, 1'b0, 1, t);

    for (int t = 0; t < 6; t++) applyStimulus(1'b1, 1'b0, 1, t);
    applyStimulus(1'b1, 1'b1, 1, 6);
    for (int t = 0; t < 20; t++) applyStimulus(1'b1, 1'b0, 1, t);

    for (int t = 0; t < 10; t++) applyStimulus(1'b1, 1'b0, 1, t);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput('0, "async_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 16; t++) applyStimulus(1'b1, 1'b0, 0, t);
    idle(PLEN + 4);

    for (int t = 0; t < 24; t++) applyStimulus(1'b1, 1'b0, 2, t);
    idle(PLEN + 4);

    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3, 1, i);
    idle(PLEN + 4);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
